cmps_repne_sequencer_de: RTL

Decode-stage micro-op sequencer for CMPS and REPNE CMPS. Holds the decode latch while it emits the CMPS first/second uop pair. For REPNE it re-issues the pair each iteration until writeback reports termination, using the repne-terminate and halt indications raised at the end of the pipe. It also freezes issue permanently when writeback signals halt.

---
 rtl/cmps_repne_sequencer_de_pkg.sv | 14 +
 rtl/cmps_repne_sequencer_de_sat_counter_en.sv | 26 ++
 rtl/cmps_repne_sequencer_de.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cmps_repne_sequencer_de_pkg.sv
// Shared definitions for the CMPS / REPNE CMPS decode sequencer.
package cmps_repne_sequencer_de_pkg;

   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FIRST   = 3'd1,
      ST_SECOND  = 3'd2,
      ST_WAIT_WB = 3'd3,
      ST_HALTED  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/cmps_repne_sequencer_de_sat_counter_en.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter_en #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/cmps_repne_sequencer_de.sv
// Decode-stage sequencer: emits the CMPS first/second uop pair, loops it for
// REPNE until writeback terminates, and freezes permanently on HALT.
module cmps_repne_sequencer_de
   import cmps_repne_sequencer_de_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             DE_V,
   input  logic             DE_IS_CMPS,
   input  logic             DE_REPNE,
   input  logic             DE_ECX_ZERO,
   input  logic             PIPE_STALL,
   input  logic             WB_V,
   input  logic             WB_CMPS_SECOND_DONE,
   input  logic             REPNE_TERMINATE_ALL,
   input  logic             HALT_ALL,
   output logic             UOP_V,
   output logic             CS_IS_CMPS_FIRST_UOP,
   output logic             CS_IS_CMPS_SECOND_UOP,
   output logic             DE_REPNE_OUT,
   output logic             DE_STALL,
   output logic             HALTED,
   output logic [CNT_W-1:0] ITER_COUNT
);

   seq_state_e       state_reg, state_next;
   logic             rep_reg, rep_next;
   logic             start;
   logic             wb_done;
   logic             de_stall_next;
   logic             cnt_clr, cnt_en;
   logic [CNT_W-1:0] cnt_value;

   // A REPNE with ECX already zero is swallowed in IDLE without issuing.
   assign start   = DE_V & DE_IS_CMPS & ~(DE_REPNE & DE_ECX_ZERO);
   assign wb_done = WB_V & WB_CMPS_SECOND_DONE;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         rep_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         rep_reg   <= rep_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rep_next      = rep_reg;
      de_stall_next = 1'b0;
      cnt_clr       = 1'b0;
      cnt_en        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               rep_next      = DE_REPNE;
               cnt_clr       = 1'b1;
               de_stall_next = 1'b1;
               state_next    = ST_FIRST;
            end
         end
         ST_FIRST: begin
            de_stall_next = 1'b1;
            if (!PIPE_STALL) begin
               state_next = ST_SECOND;
            end
         end
         ST_SECOND: begin
            // Non-REPNE releases decode in the very cycle the second uop is taken.
            de_stall_next = rep_reg | PIPE_STALL;
            if (!PIPE_STALL) begin
               cnt_en     = 1'b1;
               state_next = rep_reg ? ST_WAIT_WB : ST_IDLE;
            end
         end
         ST_WAIT_WB: begin
            de_stall_next = 1'b1;
            if (wb_done) begin
               if (REPNE_TERMINATE_ALL) begin
                  de_stall_next = HALT_ALL;
                  state_next    = ST_IDLE;
               end else begin
                  state_next = ST_FIRST;
               end
            end
         end
         ST_HALTED: begin
            de_stall_next = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (HALT_ALL) begin
         state_next = ST_HALTED;
      end
   end

   sat_counter_en #(
      .W (CNT_W)
   ) u_iter_cnt (
      .clk   (CLK),
      .srst  (RST),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cnt_value)
   );

   // Outputs are forced low while reset is held, independent of the state register.
   assign UOP_V                 = ~RST & ((state_reg == ST_FIRST) | (state_reg == ST_SECOND));
   assign CS_IS_CMPS_FIRST_UOP  = ~RST & (state_reg == ST_FIRST);
   assign CS_IS_CMPS_SECOND_UOP = ~RST & (state_reg == ST_SECOND);
   assign DE_REPNE_OUT          = UOP_V & rep_reg;
   assign HALTED                = ~RST & (state_reg == ST_HALTED);
   assign DE_STALL              = ~RST & de_stall_next;
   assign ITER_COUNT            = RST ? '0 : cnt_value;

endmodule
